// File: rtl/alu_share_if.sv
// Requester/response handshake bundle between two ALU users and the sharing controller.
// The master side is the requesters; the slave side is the controller.
interface alu_share_if #(
   parameter int DATA_W = 4
);
   logic              req0_valid;
   logic [DATA_W-1:0] req0_a;
   logic [DATA_W-1:0] req0_b;
   logic [2:0]        req0_sel;
   logic              req0_ready;

   logic              req1_valid;
   logic [DATA_W-1:0] req1_a;
   logic [DATA_W-1:0] req1_b;
   logic [2:0]        req1_sel;
   logic              req1_ready;

   logic              resp0_valid;
   logic              resp0_ready;
   logic              resp1_valid;
   logic              resp1_ready;
   logic [DATA_W-1:0] resp_y;
   logic              resp_c_out;

   modport master (
      output req0_valid, req0_a, req0_b, req0_sel,
      input  req0_ready,
      output req1_valid, req1_a, req1_b, req1_sel,
      input  req1_ready,
      input  resp0_valid, resp1_valid, resp_y, resp_c_out,
      output resp0_ready, resp1_ready
   );

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_sel,
      output req0_ready,
      input  req1_valid, req1_a, req1_b, req1_sel,
      output req1_ready,
      output resp0_valid, resp1_valid, resp_y, resp_c_out,
      input  resp0_ready, resp1_ready
   );
endinterface

// File: rtl/alu_share_ctrl.sv
// Round-robin sequencer that time-shares one combinational ALU between two requesters,
// keeping at most one operation in flight (IDLE -> EXEC -> RESP).
module alu_share_ctrl #(
   parameter int DATA_W = 4,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   alu_share_if.slave        bus,
   output logic [DATA_W-1:0] o_alu_a,
   output logic [DATA_W-1:0] o_alu_b,
   output logic [2:0]        o_alu_sel,
   input  logic [DATA_W-1:0] i_alu_y,
   input  logic              i_alu_c_out,
   output logic              o_busy,
   output logic [CNT_W-1:0]  o_op_count
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   logic              r_owner;
   logic              r_last;
   logic [DATA_W-1:0] r_alu_a;
   logic [DATA_W-1:0] r_alu_b;
   logic [2:0]        r_alu_sel;
   logic [DATA_W-1:0] r_resp_y;
   logic              r_resp_c;
   logic [CNT_W-1:0]  r_op_count;

   logic              w_grant0;
   logic              w_grant1;
   logic              w_accept;
   logic              w_resp_hs;

   // r_last names the requester served most recently; reset to 1 so requester 0 wins first.
   always_comb begin
      w_state_nxt = r_state;
      w_grant0    = 1'b0;
      w_grant1    = 1'b0;
      w_resp_hs   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!rst) begin
               w_grant0 = bus.req0_valid && (!bus.req1_valid || r_last);
               w_grant1 = bus.req1_valid && (!bus.req0_valid || !r_last);
            end
            if (w_grant0 || w_grant1) begin
               w_state_nxt = S_EXEC;
            end
         end
         S_EXEC: begin
            w_state_nxt = S_RESP;
         end
         S_RESP: begin
            w_resp_hs = r_owner ? bus.resp1_ready : bus.resp0_ready;
            if (w_resp_hs) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign w_accept = w_grant0 || w_grant1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_owner    <= 1'b0;
         r_last     <= 1'b1;
         r_alu_a    <= '0;
         r_alu_b    <= '0;
         r_alu_sel  <= '0;
         r_resp_y   <= '0;
         r_resp_c   <= 1'b0;
         r_op_count <= '0;
      end else begin
         if (w_accept) begin
            r_owner   <= w_grant1;
            r_alu_a   <= w_grant1 ? bus.req1_a   : bus.req0_a;
            r_alu_b   <= w_grant1 ? bus.req1_b   : bus.req0_b;
            r_alu_sel <= w_grant1 ? bus.req1_sel : bus.req0_sel;
         end
         // The ALU has been fed from stable registers for the whole EXEC cycle.
         if (r_state == S_EXEC) begin
            r_resp_y <= i_alu_y;
            r_resp_c <= i_alu_c_out;
         end
         if (w_resp_hs) begin
            r_last     <= r_owner;
            r_op_count <= r_op_count + CNT_W'(1);
         end
      end
   end

   assign bus.req0_ready  = w_grant0;
   assign bus.req1_ready  = w_grant1;
   assign bus.resp0_valid = (r_state == S_RESP) && !r_owner;
   assign bus.resp1_valid = (r_state == S_RESP) &&  r_owner;
   assign bus.resp_y      = r_resp_y;
   assign bus.resp_c_out  = r_resp_c;

   assign o_alu_a    = r_alu_a;
   assign o_alu_b    = r_alu_b;
   assign o_alu_sel  = r_alu_sel;
   assign o_busy     = (r_state != S_IDLE);
   assign o_op_count = r_op_count;

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Sequencer/arbiter that time-shares the single combinational 4-bit ALU (A, B, sel -> y, c_out) between two requesters.
- Each requester presents an operation through a valid/ready handshake. The controller arbitrates round-robin, drives the ALU from registered operands, captures the result, and returns it through a per-requester response handshake.
- At most one operation is outstanding at any time.

Parameters:
- DATA_W, 4, operand/result width; must match the ALU (4).
- CNT_W, 8, width of the completed-operation counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_a  input  DATA_W  requester 0 operand A.
- req0_b  input  DATA_W  requester 0 operand B.
- req0_sel  input  3  requester 0 ALU opcode.
- req0_ready  output  1  controller accepts requester 0 this cycle.
- req1_valid, req1_a, req1_b, req1_sel, req1_ready: same as requester 0, for requester 1.
- resp0_valid  output  1  result available for requester 0.
- resp0_ready  input  1  requester 0 takes the result.
- resp1_valid  output  1  result available for requester 1.
- resp1_ready  input  1  requester 1 takes the result.
- resp_y  output  DATA_W  result data (shared; qualified by respN_valid).
- resp_c_out  output  1  captured ALU carry/borrow.
- alu_a  output  DATA_W  to ALU A.
- alu_b  output  DATA_W  to ALU B.
- alu_sel  output  3  to ALU sel.
- alu_y  input  DATA_W  from ALU y.
- alu_c_out  input  1  from ALU c_out.
- busy  output  1  high in EXEC or RESP.
- op_count  output  CNT_W  number of completed response handshakes.

Behaviour:
- Reset values: FSM in IDLE; all readys and resp valids 0; resp_y, resp_c_out, alu_a, alu_b, alu_sel, op_count all 0; busy 0; round-robin pointer favours requester 0.
- FSM states:
  - IDLE -> EXEC on accept.
  - EXEC -> RESP unconditionally after one cycle.
  - RESP -> IDLE on the owner's response handshake.
- IDLE:
  - reqN_ready is combinational: high only for the granted requester, only in IDLE.
  - Grant when one valid: that requester.
  - Grant when both valid: the requester not served last (pointer).
  - Accept = valid && ready. On accept, register a/b/sel into alu_a/alu_b/alu_sel and record the owner.
- EXEC:
  - ALU inputs are stable from registers for the full cycle.
  - At the clock edge ending EXEC, capture alu_y into resp_y and alu_c_out into resp_c_out.
  - The controller does not reinterpret opcodes; all 8 sel codes pass through.
- RESP:
  - resp<owner>_valid = 1. The other respN_valid stays 0.
  - resp_y and resp_c_out hold steady until the handshake.
  - On resp<owner>_ready: valid drops next cycle, the pointer records the owner, op_count increments (wraps 2^CNT_W-1 -> 0), and the FSM returns to IDLE.
- Latency: accept at edge T; respN_valid high from cycle T+2. With immediate resp_ready, the next accept can occur at cycle T+3. Sustained throughput is 1 operation per 3 cycles.
- alu_a/alu_b/alu_sel hold their last values outside EXEC (no toggling when idle).
- Both reqN_ready are 0 while busy. Requesters must hold valid and payload until accepted. Dropping valid before acceptance is legal and has no effect.
- Response backpressure: RESP may last indefinitely. No new request is accepted until the response is taken.
- respM_ready asserted by the non-owner is ignored.
- Reset has priority over everything. Reset asserted in EXEC or RESP discards the operation: no response is issued, state goes to IDLE, and the pointer returns to its default.
- Request and reset in the same cycle: reset wins; no accept.

Test Plan:
- Req0 only: a=0011, b=0101, sel=000 -> resp0_valid at T+2, resp_y=1000, resp_c_out=0, op_count=1, resp1_valid stays 0.
- Req1 only: a=1111, b=0001, sel=000 -> resp_y=0000, resp_c_out=1 returned on resp1. Then SUB a=0110, b=0011, sel=001 -> resp_y=0011.
- Both valid continuously from reset: req0 (1100 AND 1010 -> 1000) served first, then req1 (1100 XOR 1010 -> 0110), then req0 again. Grants strictly alternate; each accept spaced 3 cycles apart with resp_ready tied high.
- Backpressure: hold resp0_ready=0 for 5 cycles after resp0_valid -> resp_y, resp_c_out stable; busy=1; req1_ready=0 throughout; req1 accepted the cycle after the handshake returns FSM to IDLE.
- Reset mid-op: accept req0 (sel=110, a=0001), assert rst during EXEC -> no resp0_valid; all outputs at reset values; op_count=0; next accept works normally.
- Counter wrap: with CNT_W=2, complete 5 operations -> op_count sequence 1, 2, 3, 0, 1.
